// File: rtl/auto_parkcalc_deadlock_defs_pkg.sv
// Shared deadlock-reporting definitions: FSM encoding and parameter defaults,
// used by the reporter and the monitor wrapper level.
package auto_parkcalc_deadlock_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WATCH  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HELD   = 2'd3
  } dl_state_e;

  localparam int unsigned DL_THRESHOLD_DEF = 1024;
  localparam int unsigned DL_CNT_W_DEF     = 32;

  function automatic int unsigned dl_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/auto_parkcalc_deadlock_prio_enc.sv
// Lowest-set-bit index encoder; an all-zero input yields index 0.
module auto_parkcalc_deadlock_prio_enc
  import auto_parkcalc_deadlock_defs_pkg::*;
#(
  parameter int unsigned NUM_MON = 4,
  parameter int unsigned IDX_W   = dl_idx_w(NUM_MON)
) (
  input  logic [NUM_MON-1:0] vec_i,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/auto_parkcalc_hls_deadlock_reporter.sv
// Collects HLS monitor block flags, declares a deadlock after THRESHOLD
// consecutive blocked cycles, and hands out one latched snapshot over valid/ready.
module auto_parkcalc_hls_deadlock_reporter
  import auto_parkcalc_deadlock_defs_pkg::*;
#(
  parameter int unsigned NUM_MON   = 4,
  parameter int unsigned THRESHOLD = DL_THRESHOLD_DEF,
  parameter int unsigned CNT_W     = DL_CNT_W_DEF,
  localparam int unsigned IDX_W    = dl_idx_w(NUM_MON)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] block_sigs,
  input  logic               clear,
  output logic               deadlock,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [NUM_MON-1:0] rpt_mask,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [CNT_W-1:0]   rpt_cycle
);

  localparam logic [CNT_W-1:0] PERSIST_LAST = CNT_W'(THRESHOLD - 1);

  dl_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, persist_q, persist_d, stamp_q, stamp_d;
  logic [NUM_MON-1:0] rpt_mask_q;
  logic [IDX_W-1:0]   rpt_idx_q, enc_idx;
  logic [CNT_W-1:0]   rpt_cycle_q;
  logic               any_blk, capture;

  assign any_blk = |block_sigs;

  auto_parkcalc_deadlock_prio_enc #(.NUM_MON(NUM_MON), .IDX_W(IDX_W)) u_prio_enc (
    .vec_i (block_sigs),
    .idx_o (enc_idx)
  );

  always_comb begin
    state_d   = state_q;
    persist_d = persist_q;
    stamp_d   = stamp_q;
    capture   = 1'b0;
    if (clear) begin
      state_d   = ST_IDLE;
      persist_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (any_blk) begin
          state_d   = ST_WATCH;
          persist_d = CNT_W'(1);
          stamp_d   = cyc_q;
        end
        ST_WATCH: begin
          if (!any_blk) begin
            state_d   = ST_IDLE;
            persist_d = '0;
          end else if (persist_q == PERSIST_LAST) begin
            state_d   = ST_REPORT;
            persist_d = '0;
            capture   = 1'b1;
          end else begin
            persist_d = persist_q + CNT_W'(1);
          end
        end
        ST_REPORT: if (rpt_ready) state_d = ST_HELD;
        ST_HELD:   state_d = ST_HELD;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      persist_q   <= '0;
      stamp_q     <= '0;
      rpt_mask_q  <= '0;
      rpt_idx_q   <= '0;
      rpt_cycle_q <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_q + CNT_W'(1);
      persist_q <= persist_d;
      stamp_q   <= stamp_d;
      if (capture) begin
        rpt_mask_q  <= block_sigs;
        rpt_idx_q   <= enc_idx;
        rpt_cycle_q <= stamp_q;
      end
    end
  end

  assign deadlock  = (state_q == ST_REPORT) || (state_q == ST_HELD);
  assign rpt_valid = (state_q == ST_REPORT);
  assign rpt_mask  = rpt_mask_q;
  assign rpt_idx   = rpt_idx_q;
  assign rpt_cycle = rpt_cycle_q;

endmodule
